// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer and its per-digit counters.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Any non-decimal nibble is clamped to the largest legal digit value.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/counter_4bit_9_0.sv
// One BCD down-counting digit (9 -> 0 -> 9) with a parallel load and a ripple borrow.
module counter_4bit_9_0
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       borrow_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_digit;
    end else if (borrow_in) begin
      value <= (value == 4'd0) ? BCD_MAX : value - 4'd1;
    end
  end

  assign borrow_out = borrow_in && (value == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: load, start/pause control, decrement per tick,
// one-cycle done pulse on reaching zero.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   value,
  output logic                  busy,
  output logic                  zero,
  output logic                  done
);

  localparam int VALUE_W = 4 * DIGITS;

  timer_state_t         state;
  timer_state_t         next_state;
  logic                 next_done;
  logic                 dec_en;
  logic                 is_one;
  logic [VALUE_W-1:0]   clamped_value;
  logic [DIGITS:0]      borrow;
  logic                 unused_borrow;

  assign zero   = (value == '0);
  assign is_one = (value == VALUE_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= next_done;
    end
  end

  // load overrides everything; pause beats tick while running.
  always_comb begin
    next_state = state;
    next_done  = 1'b0;
    dec_en     = 1'b0;
    if (load) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = zero ? DONE : RUN;
            next_done  = zero;
          end
        end
        RUN: begin
          if (pause) begin
            next_state = PAUSED;
          end else if (tick && !zero) begin
            dec_en = 1'b1;
            if (is_one) begin
              next_state = DONE;
              next_done  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            next_state = RUN;
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  assign borrow[0]     = dec_en;
  assign unused_borrow = borrow[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign clamped_value[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);

    counter_4bit_9_0 u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (clamped_value[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .value      (value[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (DIGITS = 4).
module tb_bcd_countdown_timer;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic        tick;
  logic [15:0] value;
  logic        busy;
  logic        zero;
  logic        done;

  int checks;
  int errors;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .value      (value),
    .busy       (busy),
    .zero       (zero),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic l, input logic [15:0] lv, input logic s,
                            input logic p, input logic t);
    load = l; load_value = lv; start = s; pause = p; tick = t;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int k;
    k = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #3;
    checks++; if (value !== 16'h0000) begin errors++; $display("[TB] FAIL reset_value got %h want 0000", value); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_flags got busy=%b done=%b zero=%b want 0 0 1", busy, done, zero); end
    cycle();
    reset = 1'b0;
    // Mid-run reset with tick held high.
    set_inputs(1'b1, 16'h0347, 1'b0, 1'b0, 1'b0); cycle();
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle(); cycle();
    checks++; if (value !== 16'h0345 || busy !== 1'b1) begin errors++; $display("[TB] FAIL prereset_run got %h busy=%b want 0345 1", value, busy); end
    #2; reset = 1'b1; #1;
    checks++; if (value !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset got %h busy=%b done=%b want 0000 0 0", value, busy, done); end
    cycle();
    reset = 1'b0;
    cycle();
    checks++; if (value !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got %h busy=%b done=%b want 0000 0 0", value, busy, done); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_borrow_countdown();
    int expected;
    set_inputs(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (value !== 16'h0100 || busy !== 1'b0) begin errors++; $display("[TB] FAIL load_0100 got %h busy=%b want 0100 0", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0100 || busy !== 1'b1) begin errors++; $display("[TB] FAIL start_0100 got %h busy=%b want 0100 1", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0099) begin errors++; $display("[TB] FAIL borrow_0099 got %h want 0099", value); end
    cycle();
    checks++; if (value !== 16'h0098) begin errors++; $display("[TB] FAIL borrow_0098 got %h want 0098", value); end
    expected = 98;
    while (expected > 1) begin
      cycle();
      expected--;
      checks++; if (value !== to_bcd(expected) || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL countdown got %h done=%b busy=%b want %h 0 1", value, done, busy, to_bcd(expected)); end
    end
    cycle();
    checks++; if (value !== 16'h0000 || done !== 1'b1 || busy !== 1'b0 || zero !== 1'b1) begin errors++; $display("[TB] FAIL reach_zero got %h done=%b busy=%b zero=%b want 0000 1 0 1", value, done, busy, zero); end
    cycle();
    checks++; if (value !== 16'h0000 || done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle got %h done=%b want 0000 0", value, done); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL done_hold got %h done=%b busy=%b want 0000 0 0", value, done, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pause_resume();
    set_inputs(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0); cycle();
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle(); cycle();
    checks++; if (value !== 16'h0003) begin errors++; $display("[TB] FAIL two_ticks got %h want 0003", value); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1); cycle();
    checks++; if (value !== 16'h0003 || busy !== 1'b0) begin errors++; $display("[TB] FAIL pause_beats_tick got %h busy=%b want 0003 0", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle(); cycle(); cycle();
    checks++; if (value !== 16'h0003 || busy !== 1'b0) begin errors++; $display("[TB] FAIL paused_ticks got %h busy=%b want 0003 0", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0); cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_with_pause got busy=%b want 0", busy); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    checks++; if (value !== 16'h0003 || busy !== 1'b1) begin errors++; $display("[TB] FAIL resume got %h busy=%b want 0003 1", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0002) begin errors++; $display("[TB] FAIL resume_tick got %h want 0002", value); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clamp_and_zero_start();
    set_inputs(1'b1, 16'h00A3, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (value !== 16'h0093 || busy !== 1'b0) begin errors++; $display("[TB] FAIL clamp_00A3 got %h busy=%b want 0093 0", value, busy); end
    set_inputs(1'b1, 16'hFA9B, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (value !== 16'h9999) begin errors++; $display("[TB] FAIL clamp_FA9B got %h want 9999", value); end
    set_inputs(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();
    checks++; if (value !== 16'h0000 || zero !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL load_zero got %h zero=%b done=%b want 0000 1 0", value, zero, done); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || value !== 16'h0000) begin errors++; $display("[TB] FAIL start_at_zero got done=%b busy=%b value=%h want 1 0 0000", done, busy, value); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
    checks++; if (done !== 1'b0 || value !== 16'h0000) begin errors++; $display("[TB] FAIL zero_done_once got done=%b value=%h want 0 0000", done, value); end
    cycle();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_hold got done=%b busy=%b want 0 0", done, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_priority();
    set_inputs(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0); cycle();
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    checks++; if (value !== 16'h0042 || busy !== 1'b1) begin errors++; $display("[TB] FAIL run_0042 got %h busy=%b want 0042 1", value, busy); end
    set_inputs(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h1234 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL load_wins got %h busy=%b done=%b want 1234 0 0", value, busy, done); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1); cycle();
    checks++; if (value !== 16'h1234 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignores_tick got %h busy=%b want 1234 0", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_inputs(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0); cycle();
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0010 || busy !== 1'b1) begin errors++; $display("[TB] FAIL start_tick_same got %h busy=%b want 0010 1", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0009) begin errors++; $display("[TB] FAIL first_tick got %h want 0009", value); end
    set_inputs(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
    checks++; if (value !== 16'h0008 || busy !== 1'b1) begin errors++; $display("[TB] FAIL run_ignores_start got %h busy=%b want 0008 1", value, busy); end
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    set_inputs(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_borrow_countdown();
    test_pause_resume();
    test_clamp_and_zero_start();
    test_load_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
